cpu_control_unit: RTL and testbench

Hardwired Moore control unit that sequences the existing datapath through instruction fetch and R-format ALU execution. It replaces hand-driven control strobes with a T-state FSM. The FSM takes IR contents and a memory-ready handshake as inputs, and drives the datapath's register-select, bus-source, latch-enable and ALU-op strobes. It sits beside the datapath; every strobe output connects to the same-named datapath input.

---
 rtl/cpu_control_unit_pkg.sv | 62 ++++++
 rtl/cpu_control_unit_if.sv | 25 ++
 rtl/cpu_control_unit_opcode_decode.sv | 52 +++++
 rtl/cpu_control_unit.sv | 186 ++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_control_unit_pkg.sv
// cpu_ctrl_pkg: shared constants for the hardwired control unit.
//   - T-state encodings (IDLE, T0..T6), 4 bits wide
//   - 5-bit opcode values for the R-format ALU instructions
//   - bit positions within the one-hot alu_op vector (bit0 = AND)
//   - IR field bit positions: op[31:27], Ra[26:23], Rb[22:19], Rc[18:15]
//   - reg_sel(): 4-bit register number to 16-bit one-hot select
package cpu_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t IDLE = 4'd0;
  localparam state_t T0   = 4'd1;
  localparam state_t T1   = 4'd2;
  localparam state_t T2   = 4'd3;
  localparam state_t T3   = 4'd4;
  localparam state_t T4   = 4'd5;
  localparam state_t T5   = 4'd6;
  localparam state_t T6   = 4'd7;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam int unsigned ALU_W    = 13;
  localparam int unsigned ALU_AND  = 0;
  localparam int unsigned ALU_OR   = 1;
  localparam int unsigned ALU_ADD  = 2;
  localparam int unsigned ALU_SUB  = 3;
  localparam int unsigned ALU_MUL  = 4;
  localparam int unsigned ALU_DIV  = 5;
  localparam int unsigned ALU_SHR  = 6;
  localparam int unsigned ALU_SHRA = 7;
  localparam int unsigned ALU_SHL  = 8;
  localparam int unsigned ALU_ROR  = 9;
  localparam int unsigned ALU_ROL  = 10;
  localparam int unsigned ALU_NEG  = 11;
  localparam int unsigned ALU_NOT  = 12;

  localparam int unsigned OP_HI = 31;
  localparam int unsigned OP_LO = 27;
  localparam int unsigned RA_HI = 26;
  localparam int unsigned RA_LO = 23;
  localparam int unsigned RB_HI = 22;
  localparam int unsigned RB_LO = 19;
  localparam int unsigned RC_HI = 18;
  localparam int unsigned RC_LO = 15;

  function automatic logic [15:0] reg_sel(input logic [3:0] n);
    return 16'd1 << n;
  endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// cpu_control_unit_if: control-unit <-> datapath connection.
//   master (control unit): receives ir, mem_ready; drives Rout/Rin one-hot
//     register selects, the single-bit datapath strobes and one-hot alu_op.
//   slave (datapath): the mirror image.
interface cpu_control_unit_if;
  logic [31:0] ir;
  logic        mem_ready;
  logic [15:0] Rout;
  logic [15:0] Rin;
  logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read;
  logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic [12:0] alu_op;

  modport master (
    input  ir, mem_ready,
    output Rout, Rin, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read,
           Yin, Zin, Zlowout, Zhighout, HIin, LOin, alu_op
  );

  modport slave (
    output ir, mem_ready,
    input  Rout, Rin, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read,
           Yin, Zin, Zlowout, Zhighout, HIin, LOin, alu_op
  );
endinterface

// File: rtl/cpu_control_unit_opcode_decode.sv
// cpu_opcode_decode: combinational opcode classifier.
//   op         in  5   IR opcode field
//   alu_op     out 13  one-hot ALU operation (all zero when illegal)
//   is_unary   out 1   NEG / NOT (single source operand)
//   is_muldiv  out 1   MUL / DIV (64-bit result via HI/LO)
//   is_illegal out 1   opcode not in the instruction set
module cpu_opcode_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0]       op,
  output logic [ALU_W-1:0] alu_op,
  output logic             is_unary,
  output logic             is_muldiv,
  output logic             is_illegal
);

  always_comb begin
    alu_op     = '0;
    is_unary   = 1'b0;
    is_muldiv  = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_ADD:  alu_op[ALU_ADD]  = 1'b1;
      OP_SUB:  alu_op[ALU_SUB]  = 1'b1;
      OP_SHR:  alu_op[ALU_SHR]  = 1'b1;
      OP_SHRA: alu_op[ALU_SHRA] = 1'b1;
      OP_SHL:  alu_op[ALU_SHL]  = 1'b1;
      OP_ROR:  alu_op[ALU_ROR]  = 1'b1;
      OP_ROL:  alu_op[ALU_ROL]  = 1'b1;
      OP_AND:  alu_op[ALU_AND]  = 1'b1;
      OP_OR:   alu_op[ALU_OR]   = 1'b1;
      OP_MUL: begin
        alu_op[ALU_MUL] = 1'b1;
        is_muldiv       = 1'b1;
      end
      OP_DIV: begin
        alu_op[ALU_DIV] = 1'b1;
        is_muldiv       = 1'b1;
      end
      OP_NEG: begin
        alu_op[ALU_NEG] = 1'b1;
        is_unary        = 1'b1;
      end
      OP_NOT: begin
        alu_op[ALU_NOT] = 1'b1;
        is_unary        = 1'b1;
      end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: hardwired Moore T-state sequencer for fetch and
// R-format ALU execution.
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   step        in   (only with CPU_CONTROL_STEP_EN) single-step enable
//   run         in   keep executing; sampled in IDLE and at the end of T5/T6
//   bus         master modport of cpu_control_unit_if (ir, mem_ready in;
//               register selects, datapath strobes, alu_op out)
//   busy        out  FSM not in IDLE
//   illegal_op  out  high during T3 of an undecodable opcode
//   mem_err     out  one-cycle pulse on the IDLE cycle after a fetch timeout
// Parameter MEM_TIMEOUT (1..255): T1 cycles spent waiting on mem_ready
// before the fetch is abandoned.
// Define CPU_CONTROL_STEP_EN to add the step input: every transition other
// than reset and the T1 wait then also needs step=1; the timeout counter
// keeps running regardless.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef CPU_CONTROL_STEP_EN
  input  logic                     step,
`endif
  input  logic                     run,
  cpu_control_unit_if.master       bus,
  output logic                     busy,
  output logic                     illegal_op,
  output logic                     mem_err
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [7:0]       wait_cnt, wait_cnt_nxt;
  logic             mem_err_nxt;
  logic             adv;
  logic [ALU_W-1:0] dec_alu_op;
  logic             is_unary, is_muldiv, is_illegal;
  logic [3:0]       ra, rb, rc;
  logic             unused_ir;

`ifdef CPU_CONTROL_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  assign ra        = bus.ir[RA_HI:RA_LO];
  assign rb        = bus.ir[RB_HI:RB_LO];
  assign rc        = bus.ir[RC_HI:RC_LO];
  assign unused_ir = ^bus.ir[RC_LO-1:0];

  cpu_opcode_decode u_decode (
    .op         (bus.ir[OP_HI:OP_LO]),
    .alu_op     (dec_alu_op),
    .is_unary   (is_unary),
    .is_muldiv  (is_muldiv),
    .is_illegal (is_illegal)
  );

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_err_nxt  = 1'b0;
    case (state)
      IDLE: if (run && adv) state_nxt = T0;
      T0:   if (adv) state_nxt = T1;
      T1: begin
        // mem_ready wins on the last wait cycle; at the limit with step
        // low the counter parks until the abort can be taken.
        if (bus.mem_ready && adv) begin
          state_nxt    = T2;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == TMO_LAST) begin
          if (!bus.mem_ready && adv) begin
            state_nxt    = IDLE;
            wait_cnt_nxt = '0;
            mem_err_nxt  = 1'b1;
          end
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      T2:   if (adv) state_nxt = T3;
      T3: begin
        if (adv) begin
          if (is_illegal)    state_nxt = IDLE;
          else if (is_unary) state_nxt = T5;
          else               state_nxt = T4;
        end
      end
      T4:   if (adv) state_nxt = T5;
      T5: begin
        if (adv) begin
          if (is_muldiv) state_nxt = T6;
          else           state_nxt = run ? T0 : IDLE;
        end
      end
      T6:   if (adv) state_nxt = run ? T0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= mem_err_nxt;
    end
  end

  always_comb begin
    bus.Rout     = '0;
    bus.Rin      = '0;
    bus.alu_op   = '0;
    bus.PCout    = 1'b0;
    bus.PCin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.MARin    = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Read     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zin      = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    illegal_op   = 1'b0;
    case (state)
      T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.PCin  = 1'b1;
      end
      T1: begin
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      T3: begin
        if (is_illegal) begin
          illegal_op = 1'b1;
        end else begin
          bus.Rout = reg_sel(rb);
          if (is_unary) begin
            bus.alu_op = dec_alu_op;
            bus.Zin    = 1'b1;
          end else begin
            bus.Yin = 1'b1;
          end
        end
      end
      T4: begin
        bus.Rout   = reg_sel(rc);
        bus.alu_op = dec_alu_op;
        bus.Zin    = 1'b1;
      end
      T5: begin
        bus.Zlowout = 1'b1;
        if (is_muldiv) bus.LOin = 1'b1;
        else           bus.Rin  = reg_sel(ra);
      end
      T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: self-checking bench for cpu_control_unit.
// Each instruction is expanded into an expected per-cycle trace (inputs to
// drive plus outputs required) from the instruction-level timing rules,
// then replayed against the DUT cycle by cycle.
module tb_cpu_control_unit;

  localparam int S_PCOUT = 13, S_PCIN = 12, S_INCPC = 11, S_MARIN = 10;
  localparam int S_MDRIN = 9,  S_MDROUT = 8, S_IRIN = 7, S_READ = 6;
  localparam int S_YIN = 5, S_ZIN = 4, S_ZLO = 3, S_ZHI = 2, S_HIIN = 1, S_LOIN = 0;

  typedef struct {
    string       ph;
    logic        run;
    logic        mr;
    logic [31:0] ir;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [12:0] alu;
    logic [13:0] strb;
    logic        busy;
    logic        ill;
    logic        merr;
  } cyc_t;

  logic clk = 1'b0;
  logic reset;
  logic run;
  logic busy, illegal_op, mem_err;
  int   n_cmp = 0;
  int   n_err = 0;
  logic need_start = 1'b1;
  cyc_t q[$];

  always #5 clk = ~clk;

  cpu_control_unit_if bus ();

  cpu_control_unit #(.MEM_TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef CPU_CONTROL_STEP_EN
    .step       (1'b1),
`endif
    .run        (run),
    .bus        (bus),
    .busy       (busy),
    .illegal_op (illegal_op),
    .mem_err    (mem_err)
  );

  wire [13:0] dut_strb = {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin,
                          bus.MDRout, bus.IRin, bus.Read, bus.Yin, bus.Zin,
                          bus.Zlowout, bus.Zhighout, bus.HIin, bus.LOin};

  // ALU one-hot bit for an opcode, -1 when the opcode is not an instruction.
  function automatic int alu_bit(input logic [4:0] op);
    case (op)
      5'd3:  return 2;   // ADD
      5'd4:  return 3;   // SUB
      5'd5:  return 6;   // SHR
      5'd6:  return 7;   // SHRA
      5'd7:  return 8;   // SHL
      5'd8:  return 9;   // ROR
      5'd9:  return 10;  // ROL
      5'd10: return 0;   // AND
      5'd11: return 1;   // OR
      5'd15: return 4;   // MUL
      5'd16: return 5;   // DIV
      5'd17: return 11;  // NEG
      5'd18: return 12;  // NOT
      default: return -1;
    endcase
  endfunction

  // A cycle with nothing expected; inputs are junk the DUT must ignore.
  function automatic cyc_t blank(input string ph);
    cyc_t c;
    c.ph   = ph;
    c.run  = 1'($urandom);
    c.mr   = 1'($urandom);
    c.ir   = $urandom;
    c.rout = '0;
    c.rin  = '0;
    c.alu  = '0;
    c.strb = '0;
    c.busy = 1'b0;
    c.ill  = 1'b0;
    c.merr = 1'b0;
    return c;
  endfunction

  task automatic push_idle(input logic r, input logic merr);
    cyc_t c;
    c      = blank("IDLE");
    c.run  = r;
    c.merr = merr;
    q.push_back(c);
  endtask

  // waits = T1 cycles with mem_ready low before it rises; >= 15 is a timeout.
  task automatic gen_instr(input logic [4:0] op, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [3:0] rc,
                           input int waits, input logic cont);
    cyc_t        c;
    logic [31:0] word;
    int          ab;
    logic        unary, muldiv;
    word   = {op, ra, rb, rc, 15'($urandom)};
    ab     = alu_bit(op);
    unary  = (op == 5'd17) || (op == 5'd18);
    muldiv = (op == 5'd15) || (op == 5'd16);
    if (need_start) push_idle(1'b1, 1'b0);
    need_start = 1'b1;

    c = blank("T0");
    c.busy = 1'b1;
    c.strb[S_PCOUT] = 1'b1; c.strb[S_MARIN] = 1'b1;
    c.strb[S_INCPC] = 1'b1; c.strb[S_PCIN]  = 1'b1;
    q.push_back(c);

    for (int i = 0; i < ((waits >= 15) ? 15 : waits + 1); i++) begin
      c = blank("T1");
      c.busy = 1'b1;
      c.strb[S_READ] = 1'b1; c.strb[S_MDRIN] = 1'b1;
      c.mr = (waits < 15) && (i == waits);
      q.push_back(c);
    end
    if (waits >= 15) begin
      push_idle(1'b0, 1'b1);
      return;
    end

    c = blank("T2");
    c.busy = 1'b1;
    c.strb[S_MDROUT] = 1'b1; c.strb[S_IRIN] = 1'b1;
    q.push_back(c);

    c = blank("T3");
    c.ir   = word;
    c.busy = 1'b1;
    if (ab < 0) begin
      c.ill = 1'b1;
      q.push_back(c);
      push_idle(1'b0, 1'b0);
      return;
    end
    c.rout = 16'd1 << rb;
    if (unary) begin
      c.alu = 13'd1 << ab;
      c.strb[S_ZIN] = 1'b1;
    end else begin
      c.strb[S_YIN] = 1'b1;
    end
    q.push_back(c);

    if (!unary) begin
      c = blank("T4");
      c.ir   = word;
      c.busy = 1'b1;
      c.rout = 16'd1 << rc;
      c.alu  = 13'd1 << ab;
      c.strb[S_ZIN] = 1'b1;
      q.push_back(c);
    end

    c = blank("T5");
    c.ir   = word;
    c.busy = 1'b1;
    c.strb[S_ZLO] = 1'b1;
    if (muldiv) c.strb[S_LOIN] = 1'b1;
    else begin
      c.rin = 16'd1 << ra;
      c.run = cont;
    end
    q.push_back(c);

    if (muldiv) begin
      c = blank("T6");
      c.ir   = word;
      c.busy = 1'b1;
      c.strb[S_ZHI] = 1'b1; c.strb[S_HIIN] = 1'b1;
      c.run  = cont;
      q.push_back(c);
    end

    if (cont) need_start = 1'b0;
    else      push_idle(1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step_cycle(input cyc_t c);
    run           = c.run;
    bus.mem_ready = c.mr;
    bus.ir        = c.ir;
    #1;
    chk({c.ph, ".Rout"},       32'(bus.Rout),   32'(c.rout));
    chk({c.ph, ".Rin"},        32'(bus.Rin),    32'(c.rin));
    chk({c.ph, ".alu_op"},     32'(bus.alu_op), 32'(c.alu));
    chk({c.ph, ".strobes"},    32'(dut_strb),   32'(c.strb));
    chk({c.ph, ".busy"},       32'(busy),       32'(c.busy));
    chk({c.ph, ".illegal_op"}, 32'(illegal_op), 32'(c.ill));
    chk({c.ph, ".mem_err"},    32'(mem_err),    32'(c.merr));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".Rout"},       32'(bus.Rout),   32'd0);
    chk({tag, ".Rin"},        32'(bus.Rin),    32'd0);
    chk({tag, ".alu_op"},     32'(bus.alu_op), 32'd0);
    chk({tag, ".strobes"},    32'(dut_strb),   32'd0);
    chk({tag, ".busy"},       32'(busy),       32'd0);
    chk({tag, ".illegal_op"}, 32'(illegal_op), 32'd0);
    chk({tag, ".mem_err"},    32'(mem_err),    32'd0);
  endtask

  task automatic play_all();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      step_cycle(c);
      @(posedge clk);
      #1;
    end
  endtask

  logic [4:0] legal_ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                 5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};

  initial begin
    cyc_t c;
    int   r, w, n_pre;
    logic [4:0] op;

    reset = 1'b1;
    run = 1'b1;
    bus.ir = 32'h2A2B8000;
    bus.mem_ready = 1'b0;
    #1 reset = 1'b0;
    #2 chk_zero("reset");
    @(posedge clk);
    #1 chk_zero("reset_held");
    reset = 1'b1;

    push_idle(1'b0, 1'b0);
    push_idle(1'b0, 1'b0);
    gen_instr(5'd5,  4'd4, 4'd5, 4'd7, 0, 1'b0);   // SHR R4,R5,R7
    gen_instr(5'd15, 4'd2, 4'd3, 4'd6, 0, 1'b0);   // MUL
    gen_instr(5'd18, 4'd1, 4'd9, 4'd0, 0, 1'b0);   // NOT R1,R9
    gen_instr(5'd3,  4'd1, 4'd2, 4'd3, 15, 1'b1);  // fetch timeout
    gen_instr(5'd3,  4'd1, 4'd2, 4'd3, 2, 1'b1);   // ready on 3rd T1 cycle
    gen_instr(5'd4,  4'd0, 4'd15, 4'd15, 14, 1'b1); // ready on last T1 cycle
    gen_instr(5'd31, 4'd1, 4'd2, 4'd3, 0, 1'b1);   // illegal
    gen_instr(5'd0,  4'd1, 4'd2, 4'd3, 1, 1'b1);   // illegal
    gen_instr(5'd16, 4'd7, 4'd7, 4'd7, 0, 1'b1);   // DIV, Ra=Rb=Rc
    gen_instr(5'd17, 4'd15, 4'd0, 4'd8, 1, 1'b0);  // NEG
    play_all();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) op = 5'($urandom);
      else op = legal_ops[$urandom_range(0, 12)];
      r = $urandom_range(0, 19);
      if (r < 14)      w = r % 4;
      else if (r < 17) w = 14;
      else             w = 15 + (r - 17);
      gen_instr(op, 4'($urandom), 4'($urandom), 4'($urandom), w,
                1'($urandom_range(0, 1)));
    end
    play_all();

    // Asynchronous reset in the middle of T4.
    gen_instr(5'd3, 4'd5, 4'd6, 4'd7, 1, 1'b1);
    n_pre = 0;
    while (n_pre < q.size() && q[n_pre].ph != "T4") n_pre++;
    for (int i = 0; i < n_pre; i++) begin
      c = q.pop_front();
      step_cycle(c);
      @(posedge clk);
      #1;
    end
    c = q.pop_front();
    step_cycle(c);
    reset = 1'b0;
    #1 chk_zero("async_reset");
    @(posedge clk);
    #1 chk_zero("async_reset_held");
    reset = 1'b1;
    q.delete();
    need_start = 1'b1;
    gen_instr(5'd11, 4'd3, 4'd4, 4'd5, 0, 1'b0);
    play_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
